// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_MUL = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

    // EXEC cycles needed by an opcode for an N-bit datapath
    function automatic int unsigned alu_exec_cycles(input alu_op_t op, input int unsigned n);
        return (op == OP_MUL) ? n : 1;
    endfunction

endpackage

// File: rtl/alu_multicycle_mul_shift_add_step.sv
// One shift-add multiply iteration: adds the (pre-shifted) multiplicand
// into the accumulator when the current multiplier bit is set.
module mul_shift_add_step #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] mcand_i,
    input  logic         mbit_i,
    output logic [W-1:0] acc_o
);

    // Conditional accumulate of the multiplicand
    always_comb begin
        acc_o = acc_i;
        if (mbit_i) begin
            acc_o = acc_i + mcand_i;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU (ADD/SUB/AND/shift-add MUL) with start/busy/done handshake.
// Optional flag outputs flag_z/flag_c are built when ALU_FLAGS_EN is defined.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic           flag_z,
    output logic           flag_c
`endif
);

    localparam int unsigned CW = $clog2(N) + 1;

    alu_state_t     state_q;
    alu_op_t        op_q;
    logic [2*N-1:0] opa_q;    // operand A, doubles as the left-shifting multiplicand
    logic [N-1:0]   opb_q;    // operand B, doubles as the right-shifting multiplier
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] result_q;
    logic           busy_q;
    logic           done_q;

    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] result_d;
    logic [N:0]     sum_w;
    logic [N:0]     diff_w;

    mul_shift_add_step #(
        .W (2*N)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (opa_q),
        .mbit_i  (opb_q[0]),
        .acc_o   (acc_step)
    );

    // Final result value, committed only on the EXEC->DONE edge
    always_comb begin
        sum_w    = {1'b0, opa_q[N-1:0]} + {1'b0, opb_q};
        diff_w   = {1'b0, opa_q[N-1:0]} - {1'b0, opb_q};
        result_d = '0;
        unique case (op_q)
            OP_ADD:  result_d[N:0]   = sum_w;
            OP_SUB:  result_d[N:0]   = diff_w;
            OP_AND:  result_d[N-1:0] = opa_q[N-1:0] & opb_q;
            OP_MUL:  result_d        = acc_step;
            default: result_d        = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic flag_z_q;
    logic flag_c_q;
    logic flag_c_d;

    // Carry flag source depends on the operation class
    always_comb begin
        flag_c_d = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB: flag_c_d = result_d[N];
            OP_AND:         flag_c_d = 1'b0;
            OP_MUL:         flag_c_d = |result_d[2*N-1:N];
            default:        flag_c_d = 1'b0;
        endcase
    end

    // Flags registered alongside result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state_q == S_EXEC && cnt_q == CW'(1)) begin
            flag_z_q <= (result_d == '0);
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

    // Control FSM with registered busy/done; also owns operand, counter and result state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= alu_op_t'(op);
                        opa_q   <= {{N{1'b0}}, a};
                        opb_q   <= b;
                        acc_q   <= '0;
                        cnt_q   <= CW'(alu_exec_cycles(alu_op_t'(op), N));
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The shift-add step runs every EXEC cycle; single-cycle ops
                    // ignore it, and the last MUL step feeds result_d directly.
                    acc_q <= acc_step;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= result_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (N=8): directed cases plus random ops
// against an arithmetic reference model. Flag checks active with ALU_FLAGS_EN.
module tb_alu_multicycle;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
`ifdef ALU_FLAGS_EN
    logic           flag_z;
    logic           flag_c;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    alu_multicycle #(
        .N (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef ALU_FLAGS_EN
        ,
        .flag_z (flag_z),
        .flag_c (flag_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: result from the arithmetic definition of each opcode
    function automatic int model_result(input int o, input int x, input int y);
        case (o)
            0:       return x + y;
            1:       return ((x - y) & 255) + ((x < y) ? 256 : 0);
            2:       return x & y;
            default: return x * y;
        endcase
    endfunction

    function automatic int model_latency(input int o);
        return (o == 3) ? N : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, follow it to done and the return to IDLE.
    // scramble: change inputs during EXEC; hold: keep start high throughout.
    task automatic run_op(input int o, input int x, input int y, input bit scramble, input bit hold);
        int exp_res;
        int exp_lat;
        int edges;
        int busy_cnt;
        logic [15:0] prev;
        logic [15:0] er;
        exp_res  = model_result(o, x, y);
        exp_lat  = model_latency(o);
        er       = exp_res[15:0];
        prev     = result;
        op       = o[1:0];
        a        = x[7:0];
        b        = y[7:0];
        start    = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        if (scramble) begin
            a  = '0;
            b  = '0;
            op = 2'($urandom_range(0, 3));
        end
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            check("result_held_in_exec", result, prev);
            tick();
            edges++;
        end
        check("latency", edges, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("result", result, er);
`ifdef ALU_FLAGS_EN
        check("flag_z", flag_z, (er == 16'd0));
        check("flag_c", flag_c, (o < 2) ? er[8] : (o == 2) ? 1'b0 : |er[15:8]);
`endif
        tick();
        check("done_pulse_end", done, 0);
        check("busy_after_done", busy, 0);
        if (hold) begin
            // start still high: sampled only now that the FSM is back in IDLE
            tick();
            check("restart_busy", busy, 1);
            start = 1'b0;
            edges = 0;
            while (!done && edges < 40) begin
                tick();
                edges++;
            end
            check("restart_latency", edges, exp_lat);
            check("restart_result", result, er);
            tick();
        end
    endtask

    initial begin
        int o, x, y;
        rst   = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        run_op(0, 200, 100, 1'b0, 1'b0);
        run_op(1, 5, 7, 1'b0, 1'b0);
        run_op(1, 7, 7, 1'b0, 1'b0);
        run_op(3, 255, 255, 1'b1, 1'b0);
        run_op(3, 13, 11, 1'b0, 1'b1);
        run_op(2, 8'hF0, 8'h3C, 1'b0, 1'b0);
        run_op(3, 0, 200, 1'b0, 1'b0);
        run_op(3, 200, 0, 1'b0, 1'b0);
        run_op(0, 255, 255, 1'b0, 1'b0);

        // Reset during MUL EXEC cycle 4
        op    = 2'd3;
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done || busy) seen_done++;
            end
            check("no_done_after_rst", seen_done, 0);
        end
        run_op(0, 1, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = $urandom_range(0, 3);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            run_op(o, x, y, i[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
